// File: rtl/line_clear_engine.sv
// Multi-cycle line-clear engine: snapshots the static board, flashes full rows,
// then collapses them one per cycle and reports the compacted board and line counts.
module line_clear_engine #(
  parameter int COLS         = 10,
  parameter int ROWS         = 20,
  parameter int FLASH_CYCLES = 0,
  parameter int TOTAL_W      = 16,
  localparam int CNT_W       = $clog2(ROWS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [COLS*ROWS-1:0]   board_in,
  output logic                   busy,
  output logic [ROWS-1:0]        flash_mask,
  output logic                   done,
  output logic [COLS*ROWS-1:0]   board_out,
  output logic [CNT_W-1:0]       lines_cleared,
  output logic [TOTAL_W-1:0]     lines_total
);

  localparam int BW    = COLS * ROWS;
  localparam int FL_W  = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam int SUM_W = ((TOTAL_W > CNT_W) ? TOTAL_W : CNT_W) + 1;
  localparam bit HAS_FLASH = (FLASH_CYCLES > 0);
  localparam logic [FL_W-1:0] FL_LOAD = HAS_FLASH ? FL_W'(FLASH_CYCLES - 1) : '0;
  localparam logic [SUM_W-1:0] TOTAL_MAX = SUM_W'({TOTAL_W{1'b1}});

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FLASH,
    ST_COMPACT,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [BW-1:0]      work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FL_W-1:0]    fl_cnt_q, fl_cnt_d;
  logic [ROWS-1:0]    flash_mask_q, flash_mask_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BW-1:0]      board_out_q, board_out_d;
  logic [CNT_W-1:0]   lines_cleared_q, lines_cleared_d;
  logic [TOTAL_W-1:0] lines_total_q, lines_total_d;

  logic [ROWS-1:0]    full_cur;
  logic [ROWS-1:0]    full_nxt;
  logic [BW-1:0]      work_dn;
  logic [BW-1:0]      compacted;
  logic               seen;
  logic [SUM_W-1:0]   sum_w;

  always_comb begin
    full_cur = '0;
    for (int r = 0; r < ROWS; r++) begin
      full_cur[r] = &work_q[r*COLS +: COLS];
    end
  end

  // Rows at or above the lowest full row take the row above them; the top fills with 0.
  always_comb begin
    work_dn   = work_q >> COLS;
    compacted = '0;
    seen      = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      seen = seen | full_cur[r];
      if (seen) compacted[r*COLS +: COLS] = work_dn[r*COLS +: COLS];
      else      compacted[r*COLS +: COLS] = work_q[r*COLS +: COLS];
    end
  end

  always_comb begin
    full_nxt = '0;
    for (int r = 0; r < ROWS; r++) begin
      full_nxt[r] = &compacted[r*COLS +: COLS];
    end
  end

  always_comb begin
    sum_w = SUM_W'(lines_total_q) + SUM_W'(cnt_q);
  end

  always_comb begin
    state_d         = state_q;
    work_d          = work_q;
    cnt_d           = cnt_q;
    fl_cnt_d        = fl_cnt_q;
    flash_mask_d    = flash_mask_q;
    busy_d          = (state_q != ST_IDLE);
    done_d          = 1'b0;
    board_out_d     = board_out_q;
    lines_cleared_d = lines_cleared_q;
    lines_total_d   = lines_total_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          work_d  = board_in;
          cnt_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (full_cur == '0) begin
          state_d = ST_DONE;
        end else if (HAS_FLASH) begin
          flash_mask_d = full_cur;
          fl_cnt_d     = FL_LOAD;
          state_d      = ST_FLASH;
        end else begin
          state_d = ST_COMPACT;
        end
      end
      ST_FLASH: begin
        if (fl_cnt_q == '0) begin
          flash_mask_d = '0;
          state_d      = ST_COMPACT;
        end else begin
          fl_cnt_d = fl_cnt_q - FL_W'(1);
        end
      end
      ST_COMPACT: begin
        work_d = compacted;
        cnt_d  = cnt_q + CNT_W'(1);
        if (full_nxt == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d          = 1'b1;
        board_out_d     = work_q;
        lines_cleared_d = cnt_q;
        if (sum_w > TOTAL_MAX) lines_total_d = '1;
        else                   lines_total_d = sum_w[TOTAL_W-1:0];
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      work_q          <= '0;
      cnt_q           <= '0;
      fl_cnt_q        <= '0;
      flash_mask_q    <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      board_out_q     <= '0;
      lines_cleared_q <= '0;
      lines_total_q   <= '0;
    end else begin
      state_q         <= state_d;
      work_q          <= work_d;
      cnt_q           <= cnt_d;
      fl_cnt_q        <= fl_cnt_d;
      flash_mask_q    <= flash_mask_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      board_out_q     <= board_out_d;
      lines_cleared_q <= lines_cleared_d;
      lines_total_q   <= lines_total_d;
    end
  end

  assign busy          = busy_q;
  assign flash_mask    = flash_mask_q;
  assign done          = done_q;
  assign board_out     = board_out_q;
  assign lines_cleared = lines_cleared_q;
  assign lines_total   = lines_total_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine: three parameterisations sharing one clock.
module tb_line_clear_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // dut0: 10x20, no flash
  logic         rst0, start0;
  logic [199:0] bin0;
  logic         busy0, done0;
  logic [19:0]  fm0;
  logic [199:0] bout0;
  logic [4:0]   lc0;
  logic [15:0]  lt0;

  // dut1: 10x20, three flash cycles
  logic         rst1, start1;
  logic [199:0] bin1;
  logic         busy1, done1;
  logic [19:0]  fm1;
  logic [199:0] bout1;
  logic [4:0]   lc1;
  logic [15:0]  lt1;

  // dut2: 6x8, 3-bit total
  logic         rst2, start2;
  logic [47:0]  bin2;
  logic         busy2, done2;
  logic [7:0]   fm2;
  logic [47:0]  bout2;
  logic [3:0]   lc2;
  logic [2:0]   lt2;

  line_clear_engine #(.COLS(10), .ROWS(20), .FLASH_CYCLES(0), .TOTAL_W(16)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .board_in(bin0), .busy(busy0),
    .flash_mask(fm0), .done(done0), .board_out(bout0), .lines_cleared(lc0),
    .lines_total(lt0));

  line_clear_engine #(.COLS(10), .ROWS(20), .FLASH_CYCLES(3), .TOTAL_W(16)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .board_in(bin1), .busy(busy1),
    .flash_mask(fm1), .done(done1), .board_out(bout1), .lines_cleared(lc1),
    .lines_total(lt1));

  line_clear_engine #(.COLS(6), .ROWS(8), .FLASH_CYCLES(0), .TOTAL_W(3)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .board_in(bin2), .busy(busy2),
    .flash_mask(fm2), .done(done2), .board_out(bout2), .lines_cleared(lc2),
    .lines_total(lt2));

  function automatic logic [199:0] row10(input int r);
    logic [199:0] m;
    m = '0;
    m[r*10 +: 10] = '1;
    return m;
  endfunction

  function automatic logic [47:0] row6(input int r);
    logic [47:0] m;
    m = '0;
    m[r*6 +: 6] = '1;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst0 = 1; rst1 = 1; rst2 = 1;
    tick(); tick();
    rst0 = 0; rst1 = 0; rst2 = 0;
    tick();
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b exp 0", busy0); end
    tests++; if (done0 !== 1'b0) begin fails++; $display("FAIL reset_done got %0b exp 0", done0); end
    tests++; if (fm0 !== 20'h0) begin fails++; $display("FAIL reset_flash_mask got %h exp 0", fm0); end
    tests++; if (bout0 !== 200'h0) begin fails++; $display("FAIL reset_board_out got %h exp 0", bout0); end
    tests++; if (lc0 !== 5'd0) begin fails++; $display("FAIL reset_lines_cleared got %0d exp 0", lc0); end
    tests++; if (lt0 !== 16'd0) begin fails++; $display("FAIL reset_lines_total got %0d exp 0", lt0); end
    tests++; if (fm1 !== 20'h0 || busy1 !== 1'b0) begin fails++; $display("FAIL reset_dut1 fm %h busy %0b exp 0 0", fm1, busy1); end
    tests++; if (lt2 !== 3'd0 || busy2 !== 1'b0) begin fails++; $display("FAIL reset_dut2 lt %0d busy %0b exp 0 0", lt2, busy2); end
  endtask

  task automatic test_empty();
    int lat;
    bin0 = '0; start0 = 1;
    tick();
    start0 = 0;
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL empty_busy_e0 got %0b exp 0", busy0); end
    tick();
    tests++; if (busy0 !== 1'b1) begin fails++; $display("FAIL empty_busy_rise got %0b exp 1", busy0); end
    lat = 1;
    while (!done0 && lat < 60) begin tick(); lat++; end
    tests++; if (lat !== 2) begin fails++; $display("FAIL empty_latency got %0d exp 2", lat); end
    tests++; if (bout0 !== 200'h0) begin fails++; $display("FAIL empty_board got %h exp 0", bout0); end
    tests++; if (lc0 !== 5'd0 || lt0 !== 16'd0) begin fails++; $display("FAIL empty_counts lc %0d lt %0d exp 0 0", lc0, lt0); end
    tests++; if (busy0 !== 1'b1) begin fails++; $display("FAIL empty_busy_at_done got %0b exp 1", busy0); end
    tick();
    tests++; if (done0 !== 1'b0 || busy0 !== 1'b0) begin fails++; $display("FAIL empty_after_done done %0b busy %0b exp 0 0", done0, busy0); end
  endtask

  task automatic test_single_row();
    logic [199:0] b, exp;
    int lat;
    b = row10(0); b[13] = 1'b1;
    exp = '0; exp[3] = 1'b1;
    bin0 = b; start0 = 1;
    tick();
    start0 = 0; bin0 = '1;
    lat = 0;
    while (!done0 && lat < 60) begin tick(); lat++; end
    bin0 = '0;
    tests++; if (lat !== 3) begin fails++; $display("FAIL single_latency got %0d exp 3", lat); end
    tests++; if (bout0 !== exp) begin fails++; $display("FAIL single_board got %h exp %h", bout0, exp); end
    tests++; if (lc0 !== 5'd1) begin fails++; $display("FAIL single_lines got %0d exp 1", lc0); end
    tests++; if (lt0 !== 16'd1) begin fails++; $display("FAIL single_total got %0d exp 1", lt0); end
    tick();
  endtask

  task automatic test_four_rows();
    logic [199:0] b, exp;
    int lat, fl, bad;
    b = row10(0) | row10(2) | row10(3) | row10(5);
    b[17] = 1'b1; b[42] = 1'b1;
    exp = '0; exp[7] = 1'b1; exp[12] = 1'b1;
    bin1 = b; start1 = 1;
    tick();
    start1 = 0; bin1 = '0;
    lat = 0; fl = 0; bad = 0;
    while (!done1 && lat < 60) begin
      if (fm1 !== 20'h0) begin
        fl++;
        if (fm1 !== 20'h0002D) bad++;
      end
      tick(); lat++;
    end
    tests++; if (fl !== 3) begin fails++; $display("FAIL four_flash_cycles got %0d exp 3", fl); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL four_flash_value wrong in %0d cycles exp 0", bad); end
    tests++; if (lat !== 9) begin fails++; $display("FAIL four_latency got %0d exp 9", lat); end
    tests++; if (bout1 !== exp) begin fails++; $display("FAIL four_board got %h exp %h", bout1, exp); end
    tests++; if (lc1 !== 5'd4 || lt1 !== 16'd4) begin fails++; $display("FAIL four_counts lc %0d lt %0d exp 4 4", lc1, lt1); end
    tests++; if (fm1 !== 20'h0) begin fails++; $display("FAIL four_mask_cleared got %h exp 0", fm1); end
    tick();
  endtask

  task automatic test_start_while_busy();
    logic [199:0] b, exp;
    int lat, extra;
    b = row10(0) | row10(2) | row10(3) | row10(5);
    b[17] = 1'b1; b[42] = 1'b1;
    exp = '0; exp[7] = 1'b1; exp[12] = 1'b1;
    bin1 = b; start1 = 1;
    tick();
    start1 = 0;
    lat = 0;
    while (!done1 && lat < 60) begin
      if (lat == 2) begin start1 = 1; bin1 = '0; end
      else if (lat == 5) begin start1 = 1; bin1 = '1; end
      else start1 = 0;
      tick(); lat++;
    end
    start1 = 0; bin1 = '0;
    tests++; if (lat !== 9) begin fails++; $display("FAIL busy_latency got %0d exp 9", lat); end
    tests++; if (bout1 !== exp) begin fails++; $display("FAIL busy_board got %h exp %h", bout1, exp); end
    tests++; if (lc1 !== 5'd4 || lt1 !== 16'd8) begin fails++; $display("FAIL busy_counts lc %0d lt %0d exp 4 8", lc1, lt1); end
    extra = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (done1 || busy1) extra++; end
    tests++; if (extra !== 0) begin fails++; $display("FAIL busy_no_restart active %0d cycles exp 0", extra); end
  endtask

  task automatic test_reset_mid_compact();
    logic [199:0] b, exp;
    int lat, seen_done;
    b = row10(0) | row10(1) | row10(2);
    bin0 = b; start0 = 1;
    tick();
    start0 = 0;
    tick(); tick();
    rst0 = 1;
    tick();
    rst0 = 0;
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %0b exp 0", busy0); end
    tests++; if (bout0 !== 200'h0 || lt0 !== 16'd0) begin fails++; $display("FAIL rst_mid_state board %h lt %0d exp 0 0", bout0, lt0); end
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin if (done0) seen_done++; tick(); end
    tests++; if (seen_done !== 0) begin fails++; $display("FAIL rst_mid_no_done got %0d pulses exp 0", seen_done); end
    b = row10(0); b[13] = 1'b1;
    exp = '0; exp[3] = 1'b1;
    bin0 = b; start0 = 1;
    tick();
    start0 = 0;
    lat = 0;
    while (!done0 && lat < 60) begin tick(); lat++; end
    tests++; if (lat !== 3) begin fails++; $display("FAIL rst_after_latency got %0d exp 3", lat); end
    tests++; if (bout0 !== exp || lc0 !== 5'd1 || lt0 !== 16'd1) begin fails++; $display("FAIL rst_after_result board %h lc %0d lt %0d exp %h 1 1", bout0, lc0, lt0, exp); end
    tick();
  endtask

  task automatic test_saturation();
    logic [47:0] b, exp;
    int lat;
    b = row6(0) | row6(1) | row6(2) | row6(3);
    b[29:24] = 6'b101001;
    exp = '0; exp[5:0] = 6'b101001;
    bin2 = b; start2 = 1;
    tick();
    start2 = 0;
    lat = 0;
    while (!done2 && lat < 60) begin tick(); lat++; end
    tests++; if (lat !== 6) begin fails++; $display("FAIL sat_a_latency got %0d exp 6", lat); end
    tests++; if (bout2 !== exp) begin fails++; $display("FAIL sat_a_board got %h exp %h", bout2, exp); end
    tests++; if (lc2 !== 4'd4 || lt2 !== 3'd4) begin fails++; $display("FAIL sat_a_counts lc %0d lt %0d exp 4 4", lc2, lt2); end
    tick();
    b = row6(1) | row6(3) | row6(5) | row6(7);
    b[5:0] = 6'b000011; b[17:12] = 6'b010000; b[29:24] = 6'b100000; b[41:36] = 6'b000100;
    exp = '0; exp[23:0] = {6'b000100, 6'b100000, 6'b010000, 6'b000011};
    bin2 = b; start2 = 1;
    tick();
    start2 = 0;
    lat = 0;
    while (!done2 && lat < 60) begin tick(); lat++; end
    tests++; if (lat !== 6) begin fails++; $display("FAIL sat_b_latency got %0d exp 6", lat); end
    tests++; if (bout2 !== exp) begin fails++; $display("FAIL sat_b_board got %h exp %h", bout2, exp); end
    tests++; if (lc2 !== 4'd4) begin fails++; $display("FAIL sat_b_lines got %0d exp 4", lc2); end
    tests++; if (lt2 !== 3'd7) begin fails++; $display("FAIL sat_b_total got %0d exp 7", lt2); end
    tick();
  endtask

  initial begin
    rst0 = 1; rst1 = 1; rst2 = 1;
    start0 = 0; start1 = 0; start2 = 0;
    bin0 = '0; bin1 = '0; bin2 = '0;
    test_reset();
    test_empty();
    test_single_row();
    test_four_rows();
    test_start_while_busy();
    test_reset_mid_compact();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
